// File: rtl/multi_core_nonce_dispatcher_pkg.sv
// Shared definitions for the multi-core nonce dispatcher.
//   state_t          : dispatcher FSM states
//   DEFAULT_NONCE_W  : default nonce width
//   OUTSTANDING_MULT : outstanding-request capacity per attached core
//   idx_width()      : core-index width, never below 1 bit
package multi_core_nonce_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_NONCE_W  = 32;
  localparam int unsigned OUTSTANDING_MULT = 4;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over a request vector.
// The search starts at index i_ptr (inclusive) and wraps; tying i_ptr to 0
// turns it into a lowest-index priority encoder.
//   i_req   : request vector
//   i_ptr   : first index to consider
//   o_grant : one-hot grant (zero when no request)
//   o_valid : at least one request present
//   o_idx   : index of the granted request
module rr_arbiter
  import multi_core_nonce_dispatcher_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    int unsigned w_pos;
    logic        w_got;
    w_pos   = 0;
    w_got   = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = (32'(i_ptr) + k) % N;
      if (!w_got && i_req[w_pos]) begin
        w_got          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IDX_W'(w_pos);
      end
    end
    o_valid = w_got;
  end

endmodule

// File: rtl/multi_core_nonce_dispatcher.sv
// Hands an inclusive nonce range out to NUM_CORES hash cores, one nonce per
// cycle in round-robin order, tracks outstanding work and captures the first
// hit (lowest core index on ties).
// Optional feature macro: EXTRANONCE_ROLL_EN -- on exhaustion without a hit,
// bump extranonce and restart the range instead of finishing.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : begin a search (IDLE/DONE only) / stop issuing
//   nonce_start/_end    : inclusive range, sampled on start
//   core_ready          : per-core accept
//   core_issue/_nonce   : one-hot issue and its nonce
//   core_rsp_valid/_hit : per-core result, hit flag
//   core_rsp_nonce      : per-core result nonce, core i in slice i
//   busy                : RUN or DRAIN
//   found/_nonce/_core  : captured first hit, held until next start
//   exhausted           : range finished without hit or abort
//   extranonce          : roll counter (0 unless EXTRANONCE_ROLL_EN)
module multi_core_nonce_dispatcher
  import multi_core_nonce_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned NONCE_W    = DEFAULT_NONCE_W,
  parameter int unsigned CORE_IDX_W = idx_width(NUM_CORES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NONCE_W-1:0]           nonce_start,
  input  logic [NONCE_W-1:0]           nonce_end,
  input  logic [NUM_CORES-1:0]         core_ready,
  output logic [NUM_CORES-1:0]         core_issue,
  output logic [NONCE_W-1:0]           core_nonce,
  input  logic [NUM_CORES-1:0]         core_rsp_valid,
  input  logic [NUM_CORES-1:0]         core_rsp_hit,
  input  logic [NUM_CORES*NONCE_W-1:0] core_rsp_nonce,
  output logic                         busy,
  output logic                         found,
  output logic [NONCE_W-1:0]           found_nonce,
  output logic [CORE_IDX_W-1:0]        found_core,
  output logic                         exhausted,
  output logic [31:0]                  extranonce
);

  localparam int unsigned CAP   = NUM_CORES * OUTSTANDING_MULT;
  localparam int unsigned OUT_W = $clog2(CAP + 1);
  localparam int unsigned CNT_W = $clog2(NUM_CORES + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  // One extra bit so an all-ones end nonce steps past the end instead of wrapping.
  logic [NONCE_W:0]      r_nonce;
  logic [NONCE_W:0]      r_end;
  logic [CORE_IDX_W-1:0] r_ptr;
  logic [OUT_W-1:0]      r_outstanding;
  logic                  r_found;
  logic [NONCE_W-1:0]    r_found_nonce;
  logic [CORE_IDX_W-1:0] r_found_core;
  logic                  r_exhausted;
  logic                  r_abort_seen;

  logic [NUM_CORES-1:0]  w_rdy_grant;
  logic                  w_rdy_any;
  logic [CORE_IDX_W-1:0] w_rdy_idx;
  logic [NUM_CORES-1:0]  w_hit_vec;
  logic [NUM_CORES-1:0]  w_hit_grant;
  logic                  w_hit_any;
  logic [CORE_IDX_W-1:0] w_hit_idx;
  logic [NONCE_W-1:0]    w_hit_nonce;

  logic                  w_busy;
  logic                  w_start_ok;
  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_capture;
  logic                  w_found_any;
  logic                  w_abort_any;
  logic                  w_done_entry;
  logic [CNT_W-1:0]      w_rsp_cnt;
  logic [OUT_W:0]        w_out_sum;
  logic [OUT_W:0]        w_rsp_ext;
  logic [OUT_W-1:0]      w_out_nxt;
  logic [CORE_IDX_W-1:0] w_ptr_nxt;

  rr_arbiter #(
    .N     (NUM_CORES),
    .IDX_W (CORE_IDX_W)
  ) u_issue_arb (
    .i_req   (core_ready),
    .i_ptr   (r_ptr),
    .o_grant (w_rdy_grant),
    .o_valid (w_rdy_any),
    .o_idx   (w_rdy_idx)
  );

  assign w_hit_vec = core_rsp_valid & core_rsp_hit;

  // Pointer fixed at 0: lowest-index hit wins.
  rr_arbiter #(
    .N     (NUM_CORES),
    .IDX_W (CORE_IDX_W)
  ) u_hit_prio (
    .i_req   (w_hit_vec),
    .i_ptr   ('0),
    .o_grant (w_hit_grant),
    .o_valid (w_hit_any),
    .o_idx   (w_hit_idx)
  );

  always_comb begin
    w_hit_nonce = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (w_hit_grant[i]) w_hit_nonce = core_rsp_nonce[i*NONCE_W +: NONCE_W];
    end
  end

  always_comb begin
    w_rsp_cnt = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      w_rsp_cnt = w_rsp_cnt + CNT_W'(core_rsp_valid[i]);
    end
  end

  assign w_busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_issue      = (r_state == ST_RUN) && (r_nonce <= r_end) &&
                        (r_outstanding < OUT_W'(CAP)) && w_rdy_any;
  assign w_last_issue = w_issue && (r_nonce == r_end);
  assign w_capture    = w_busy && !r_found && w_hit_any;
  assign w_found_any  = r_found || w_capture;
  assign w_abort_any  = r_abort_seen || (w_busy && abort);
  assign w_ptr_nxt    = (w_rdy_idx == CORE_IDX_W'(NUM_CORES - 1)) ? '0
                                                                  : w_rdy_idx + CORE_IDX_W'(1);

  // Results are only counted while a search is live, so stale responses
  // after reset or DONE cannot disturb the counter.
  assign w_out_sum = {1'b0, r_outstanding} + (OUT_W+1)'(w_issue);
  assign w_rsp_ext = (OUT_W+1)'(w_rsp_cnt);

  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_busy) begin
      if (w_out_sum > w_rsp_ext) w_out_nxt = OUT_W'(w_out_sum - w_rsp_ext);
      else                       w_out_nxt = '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_hit_any || abort || w_last_issue || (r_nonce > r_end))
          w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_outstanding == '0) begin
          if (!w_found_any && !w_abort_any) begin
`ifdef EXTRANONCE_ROLL_EN
            w_state_nxt = ST_RUN;
`else
            w_state_nxt = ST_DONE;
`endif
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_done_entry = (r_state == ST_DRAIN) && (w_state_nxt == ST_DONE);

`ifdef EXTRANONCE_ROLL_EN
  logic               w_roll;
  logic [NONCE_W-1:0] r_start_nonce;
  logic [31:0]        r_extranonce;

  assign w_roll = (r_state == ST_DRAIN) && (w_state_nxt == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_nonce <= '0;
      r_extranonce  <= '0;
    end else begin
      if (w_start_ok) r_start_nonce <= nonce_start;
      if (w_roll)     r_extranonce  <= r_extranonce + 32'd1;
    end
  end

  assign extranonce = r_extranonce;
`else
  assign extranonce = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_nonce       <= '0;
      r_end         <= '0;
      r_ptr         <= '0;
      r_outstanding <= '0;
      r_found       <= 1'b0;
      r_found_nonce <= '0;
      r_found_core  <= '0;
      r_exhausted   <= 1'b0;
      r_abort_seen  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      if (w_start_ok) begin
        r_nonce       <= {1'b0, nonce_start};
        r_end         <= {1'b0, nonce_end};
        r_found       <= 1'b0;
        r_found_nonce <= '0;
        r_found_core  <= '0;
        r_exhausted   <= 1'b0;
        r_abort_seen  <= 1'b0;
      end
      if (w_issue) begin
        r_nonce <= r_nonce + (NONCE_W+1)'(1);
        r_ptr   <= w_ptr_nxt;
      end
`ifdef EXTRANONCE_ROLL_EN
      if (w_roll) r_nonce <= {1'b0, r_start_nonce};
`endif
      if (w_capture) begin
        r_found       <= 1'b1;
        r_found_nonce <= w_hit_nonce;
        r_found_core  <= w_hit_idx;
      end
      if (w_busy && abort) r_abort_seen <= 1'b1;
      if (w_done_entry)    r_exhausted  <= !w_found_any && !w_abort_any;
    end
  end

  assign core_issue  = w_issue ? w_rdy_grant : '0;
  assign core_nonce  = w_issue ? r_nonce[NONCE_W-1:0] : '0;
  assign busy        = w_busy;
  assign found       = r_found;
  assign found_nonce = r_found_nonce;
  assign found_core  = r_found_core;
  assign exhausted   = r_exhausted;

endmodule

// File: tb/tb_multi_core_nonce_dispatcher.sv
// Randomized self-checking bench for multi_core_nonce_dispatcher.
// Behavioural cores keep per-core FIFOs of issued nonces and answer after a
// random delay; a reference model derived from the search rules predicts
// every issue, busy/found/exhausted and the captured hit.
// Honours EXTRANONCE_ROLL_EN when the design is built with it.
module tb_multi_core_nonce_dispatcher;
  localparam int unsigned NC  = 4;
  localparam int unsigned NW  = 32;
  localparam int unsigned CAP = NC * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, start, abort;
  logic [NW-1:0]    nonce_start, nonce_end;
  logic [NC-1:0]    core_ready, core_issue, core_rsp_valid, core_rsp_hit;
  logic [NW-1:0]    core_nonce;
  logic [NC*NW-1:0] core_rsp_nonce;
  logic             busy, found, exhausted;
  logic [NW-1:0]    found_nonce;
  logic [1:0]       found_core;
  logic [31:0]      extranonce;

  multi_core_nonce_dispatcher #(
    .NUM_CORES  (NC),
    .NONCE_W    (NW),
    .CORE_IDX_W (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .nonce_start    (nonce_start),
    .nonce_end      (nonce_end),
    .core_ready     (core_ready),
    .core_issue     (core_issue),
    .core_nonce     (core_nonce),
    .core_rsp_valid (core_rsp_valid),
    .core_rsp_hit   (core_rsp_hit),
    .core_rsp_nonce (core_rsp_nonce),
    .busy           (busy),
    .found          (found),
    .found_nonce    (found_nonce),
    .found_core     (found_core),
    .exhausted      (exhausted),
    .extranonce     (extranonce)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs
  int unsigned ready_pct = 100;
  int unsigned resp_pct  = 50;
  bit          rsp_en    = 1'b1;
  bit          hit_all   = 1'b0;
  bit          tgt_en    = 1'b0;
  logic [31:0] tgt_a     = '0;
  logic [31:0] tgt_b     = '0;

  // Behavioural cores and reference model
  logic [31:0] q [NC][$];
  int unsigned cur_nresp;
  bit          m_busy = 0, m_run = 0, m_found = 0, m_exh = 0, m_abort = 0;
  logic [32:0] m_next = '0, m_end = '0;
  logic [31:0] m_start = '0, m_fnonce = '0, m_ext = '0;
  int unsigned m_fcore = 0, m_rr = 0;
  int unsigned a_issues = 0, a_zero_issue = 0;

  task automatic drive();
    logic [31:0] n;
    core_rsp_valid = '0;
    core_rsp_hit   = '0;
    core_rsp_nonce = '0;
    cur_nresp      = 0;
    for (int unsigned c = 0; c < NC; c++) begin
      core_ready[c] = ($urandom_range(99) < ready_pct);
      if (rsp_en && q[c].size() > 0 && $urandom_range(99) < resp_pct) begin
        n = q[c].pop_front();
        core_rsp_valid[c]            = 1'b1;
        core_rsp_nonce[c*NW +: NW]   = n;
        core_rsp_hit[c]              = hit_all || (tgt_en && (n == tgt_a || n == tgt_b));
        cur_nresp++;
      end
    end
  endtask

  task automatic model_cycle();
    int unsigned out_cur, ci;
    logic [NC-1:0] exp_vec, hitv;
    logic [31:0]   exp_n;
    bit issued, last, past_end, cur_run, cur_busy;
    check_eq("busy", busy, m_busy);
    check_eq("found", found, m_found);
    check_eq("exhausted", exhausted, m_exh);
    check_eq("extranonce", extranonce, m_ext);
    out_cur = cur_nresp;
    for (int unsigned c = 0; c < NC; c++) out_cur += q[c].size();
    exp_vec = '0; exp_n = '0; issued = 0; last = 0; ci = 0;
    past_end = (m_next > m_end);
    cur_run  = m_run;
    cur_busy = m_busy;
    if (m_run && !past_end && out_cur < CAP) begin
      for (int unsigned k = 0; k < NC; k++) begin
        if (!issued && core_ready[(m_rr + k) % NC]) begin
          issued = 1;
          ci     = (m_rr + k) % NC;
        end
      end
    end
    if (issued) begin
      exp_vec[ci] = 1'b1;
      exp_n       = m_next[31:0];
    end
    check_eq("issue_vec", core_issue, exp_vec);
    check_eq("issue_nonce", core_nonce, exp_n);
    if (core_issue != '0) begin
      a_issues++;
      if (core_nonce == '0) a_zero_issue++;
    end
    if (issued) begin
      q[ci].push_back(m_next[31:0]);
      last   = (m_next == m_end);
      m_next = m_next + 33'd1;
      m_rr   = (ci + 1) % NC;
    end
    hitv = core_rsp_valid & core_rsp_hit;
    if (reset) begin
      m_busy = 0; m_run = 0; m_found = 0; m_exh = 0; m_abort = 0;
      m_fnonce = '0; m_fcore = 0; m_rr = 0; m_ext = '0;
      return;
    end
    if (cur_busy && !m_found && hitv != '0) begin
      m_found = 1;
      for (int c = NC - 1; c >= 0; c--) begin
        if (hitv[c]) begin
          m_fcore  = c;
          m_fnonce = core_rsp_nonce[c*NW +: NW];
        end
      end
    end
    if (cur_busy && abort) m_abort = 1;
    if (cur_run) begin
      if (hitv != '0 || abort || last || past_end) m_run = 0;
    end else if (cur_busy) begin
      if (out_cur == 0) begin
        if (!m_found && !m_abort) begin
`ifdef EXTRANONCE_ROLL_EN
          m_run  = 1;
          m_next = {1'b0, m_start};
          m_ext  = m_ext + 32'd1;
`else
          m_busy = 0;
          m_exh  = 1;
`endif
        end else begin
          m_busy = 0;
          m_exh  = 0;
        end
      end
    end else if (start) begin
      m_busy = 1; m_run = 1; m_found = 0; m_exh = 0; m_abort = 0;
      m_fnonce = '0; m_fcore = 0;
      m_next  = {1'b0, nonce_start};
      m_end   = {1'b0, nonce_end};
      m_start = nonce_start;
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned limit);
    int unsigned k = 0;
    while ((busy || m_busy) && k < limit) begin
      step();
      k++;
    end
    check_eq("idle_reached", busy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic run_search(input logic [31:0] s, input logic [31:0] e, input int unsigned limit);
    nonce_start = s;
    nonce_end   = e;
    start       = 1'b1;
    a_issues    = 0;
    a_zero_issue = 0;
    step();
    wait_idle(limit);
  endtask

  initial begin
    logic [31:0] s, e;
    int unsigned len, dly;
    bit do_abort;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    nonce_start = '0; nonce_end = '0;
    core_ready = '0; core_rsp_valid = '0; core_rsp_hit = '0; core_rsp_nonce = '0;
    step(); step();
    reset = 1'b0;
    step();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_found_nonce", found_nonce, 32'h0);
    check_eq("rst_found_core", found_core, 2'd0);

    // Hit on 0xB in range 0..15 with all cores ready
    ready_pct = 100; resp_pct = 60; tgt_en = 1; tgt_a = 32'hB; tgt_b = 32'hB;
    run_search(32'h0, 32'hF, 300);
    check_eq("hit_found", found, 1'b1);
    check_eq("hit_nonce", found_nonce, 32'h0000000B);
    check_eq("hit_core", found_core, 2'd3);
    check_eq("hit_core_model", found_core, m_fcore);
    check_eq("hit_exh", exhausted, 1'b0);

    // Simultaneous hits on cores 1 and 2
    do_reset();
    rsp_en = 0; tgt_en = 1; tgt_a = 32'h1; tgt_b = 32'h2;
    nonce_start = 32'h0; nonce_end = 32'h3; start = 1'b1;
    step();
    for (int i = 0; i < 6; i++) step();
    rsp_en = 1; resp_pct = 100;
    wait_idle(100);
    check_eq("tie_core", found_core, 2'd1);
    check_eq("tie_nonce", found_nonce, 32'h1);

    // Reset mid-RUN with 3 outstanding, then late hitting responses
    do_reset();
    tgt_en = 0; rsp_en = 0; ready_pct = 100;
    nonce_start = 32'h0; nonce_end = 32'd99; start = 1'b1; a_issues = 0;
    step();
    for (int i = 0; i < 20 && a_issues < 3; i++) step();
    check_eq("pre_rst_issues", a_issues, 3);
    ready_pct = 0;
    do_reset();
    ready_pct = 100;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_found", found, 1'b0);
    check_eq("mid_rst_exh", exhausted, 1'b0);
    check_eq("mid_rst_issue", core_issue, 4'h0);
    check_eq("mid_rst_nonce", core_nonce, 32'h0);
    check_eq("mid_rst_fnonce", found_nonce, 32'h0);
    check_eq("mid_rst_fcore", found_core, 2'd0);
    rsp_en = 1; resp_pct = 100; hit_all = 1;
    for (int i = 0; i < 4; i++) step();
    check_eq("late_rsp_found", found, 1'b0);
    check_eq("late_rsp_busy", busy, 1'b0);
    hit_all = 0; resp_pct = 50;

    // Abort mid-run
    run_search(32'h1000, 32'h1000, 10);
    nonce_start = 32'h0; nonce_end = 32'd1000; start = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    abort = 1'b1;
    step();
    wait_idle(200);
    check_eq("abort_exh", exhausted, 1'b0);
    check_eq("abort_found", found, 1'b0);

`ifdef EXTRANONCE_ROLL_EN
    // Roll: range 0..3, no hits, extranonce advances each pass
    tgt_en = 0; ready_pct = 100; resp_pct = 100;
    nonce_start = 32'h0; nonce_end = 32'h3; start = 1'b1;
    step();
    for (int i = 0; i < 300 && extranonce != 32'd2; i++) step();
    check_eq("roll_ext", extranonce, 32'd2);
    check_eq("roll_busy", busy, 1'b1);
    abort = 1'b1;
    step();
    wait_idle(100);
    check_eq("roll_abort_exh", exhausted, 1'b0);
    check_eq("roll_abort_ext", extranonce, 32'd2);
`else
    // Range 0..7, no hits
    tgt_en = 0; ready_pct = 100; resp_pct = 50;
    run_search(32'h0, 32'h7, 200);
    check_eq("r8_issues", a_issues, 8);
    check_eq("r8_exh", exhausted, 1'b1);
    check_eq("r8_found", found, 1'b0);

    // Top of the nonce space: must not wrap to 0
    run_search(32'hFFFF_FFFE, 32'hFFFF_FFFF, 100);
    check_eq("top_issues", a_issues, 2);
    check_eq("top_zero_issue", a_zero_issue, 0);
    check_eq("top_exh", exhausted, 1'b1);

    // Empty range
    run_search(32'd10, 32'd5, 50);
    check_eq("empty_issues", a_issues, 0);
    check_eq("empty_exh", exhausted, 1'b1);

    // Start while busy is ignored
    nonce_start = 32'h0; nonce_end = 32'd9; start = 1'b1; a_issues = 0;
    step();
    step();
    nonce_start = 32'd100; nonce_end = 32'd200; start = 1'b1;
    step();
    wait_idle(200);
    check_eq("busy_start_issues", a_issues, 10);
    check_eq("busy_start_exh", exhausted, 1'b1);

    // Randomized searches
    for (int t = 0; t < 25; t++) begin
      s         = $urandom;
      len       = $urandom_range(24);
      e         = (t % 7 == 6) ? s - 32'd1 : s + len;
      ready_pct = $urandom_range(100, 30);
      resp_pct  = $urandom_range(100, 20);
      tgt_en    = $urandom_range(1);
      tgt_a     = s + $urandom_range(len);
      tgt_b     = s + $urandom_range(len);
      do_abort  = ($urandom_range(3) == 0);
      dly       = $urandom_range(8);
      nonce_start = s; nonce_end = e; start = 1'b1;
      step();
      for (int unsigned i = 0; i < dly; i++) step();
      if (do_abort) abort = 1'b1;
      wait_idle(600);
      if (m_found) begin
        check_eq("rand_fnonce", found_nonce, m_fnonce);
        check_eq("rand_fcore", found_core, m_fcore);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_core_nonce_dispatcher.md
MULTI_CORE_NONCE_DISPATCHER -- requirements
Module: multi_core_nonce_dispatcher

Interface
REQ-001 Parameter NUM_CORES, default 4: number of attached hash cores, 1..16.
REQ-002 Parameter NONCE_W, default 32: nonce width in bits.
REQ-003 Parameter CORE_IDX_W, default $clog2(NUM_CORES) (minimum 1): width of the core index.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a search; honoured only in IDLE or DONE.
REQ-007 abort  in  1  stops issuing and forces a drain.
REQ-008 nonce_start  in  NONCE_W  first nonce, inclusive; sampled on start.
REQ-009 nonce_end  in  NONCE_W  last nonce, inclusive; sampled on start.
REQ-010 core_ready  in  NUM_CORES  core i can accept a nonce.
REQ-011 core_issue  out  NUM_CORES  one-hot; nonce handed to core i this cycle.
REQ-012 core_nonce  out  NONCE_W  nonce accompanying core_issue.
REQ-013 core_rsp_valid  in  NUM_CORES  core i returns a result.
REQ-014 core_rsp_hit  in  NUM_CORES  result meets target.
REQ-015 core_rsp_nonce  in  NUM_CORES*NONCE_W  nonce of the result; core i occupies slice i.
REQ-016 busy  out  1  state is RUN or DRAIN.
REQ-017 found  out  1  a hit was captured; held until the next start.
REQ-018 found_nonce  out  NONCE_W  the captured hit nonce.
REQ-019 found_core  out  CORE_IDX_W  the core that produced the hit.
REQ-020 exhausted  out  1  range completed with no hit; held until the next start.
REQ-021 extranonce  out  32  roll counter; see Configuration.

Function
REQ-022 FSM states are IDLE, RUN, DRAIN and DONE.
REQ-023 Transitions: IDLE/DONE -> RUN on start; RUN -> DRAIN on hit, abort, or last nonce issued; DRAIN -> DONE when the outstanding count is 0.
REQ-024 In RUN, at most one issue occurs per cycle, going to the next core in round-robin order after the last-issued core whose core_ready=1; core_issue and core_nonce are combinational from registered state.
REQ-025 The nonce counter is NONCE_W+1 bits wide, so nonce_end = all-ones terminates without wrapping to 0.
REQ-026 If nonce_start > nonce_end, the block goes RUN -> DRAIN -> DONE with zero issues and exhausted=1.
REQ-027 An outstanding counter of NUM_CORES*4 capacity increments on issue and decrements on each core_rsp_valid; issue and response in the same cycle net to no change.
REQ-028 On the first hit, found, found_nonce and found_core are registered 1 cycle later; later hits are ignored.
REQ-029 When several cores hit in the same cycle, the lowest core index wins.
REQ-030 exhausted is set on entry to DONE only if found=0 and no abort occurred.
REQ-031 start arriving while busy is ignored.
REQ-032 start in IDLE/DONE clears found and exhausted in the same edge.

Reset
REQ-033 Reset forces IDLE, clears the outstanding count, zeroes the round-robin pointer and sets all outputs to 0, including mid-search; in-flight core results arriving after reset are ignored.

Configuration
REQ-034 Macro EXTRANONCE_ROLL_EN.
REQ-035 When EXTRANONCE_ROLL_EN is defined: on range exhaustion with no hit, extranonce increments (wrapping mod 2^32), the counter reloads nonce_start after the drain completes, and the block re-enters RUN instead of DONE; abort still ends in DONE.
REQ-036 When EXTRANONCE_ROLL_EN is undefined: extranonce is tied to 0 and exhaustion ends in DONE with exhausted=1.

Structure
REQ-037 A shared package holds the state enum, the default NONCE_W and the outstanding-capacity multiplier constant.
REQ-038 One sub-module, rr_arbiter: a parametrised round-robin grant over core_ready, also reused as a lowest-index priority encoder for hits.

Verification
REQ-039 NUM_CORES=4, range 0..15, all cores always ready, model hits on 0x0000000B -> found=1, found_nonce=0x0000000B, found_core=3, exhausted=0.
REQ-040 Range 0..7, no hits -> exactly 8 issues, then DONE with exhausted=1 and found=0.
REQ-041 Range 0xFFFFFFFE..0xFFFFFFFF -> exactly 2 issues, no issue of 0x00000000, then exhausted=1.
REQ-042 Cores 1 and 2 hit in the same cycle -> found_core=1.
REQ-043 Reset asserted mid-RUN with 3 outstanding -> next cycle IDLE, all outputs 0, late responses ignored.
REQ-044 With EXTRANONCE_ROLL_EN, range 0..3 with no hits -> extranonce increments 0 -> 1 -> 2 across passes; abort then leads to DONE with exhausted=0.
